stage_if: RTL and testbench

//  Instruction-fetch stage; the producing end of the IF->DE interface. Drives
//  pc_out/instr_out/valid_out into the decode stage and consumes its
//  pc_update/pc_new redirect and stall_out (our stall_in).

---
 rtl/stage_if.sv | 195 +++++++++++++++++++
 tb/tb_stage_if.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_if.sv
// Instruction-fetch stage: fetches one word at a time over an SRAM-like bus and hands it to decode.
// Latency: REQ -> WAIT -> HOLD; with a one-cycle memory one instruction is held every 3 cycles, outputs registered.
// Backpressure: stall_in holds the HOLD entry stable with no bus request; only one request is ever in flight.
//
// Ports:
//   clk, resetn                      clock (rising edge), asynchronous active-low reset
//   inst_req/inst_addr               bus request valid / address (the fetch PC)
//   inst_addr_ok                     request accepted this cycle
//   inst_data_ok/inst_rdata          read data valid / read data
//   valid_out, stall_in              held entry valid to decode / decode cannot accept
//   pc_out, instr_out                PC and instruction word of the held entry
//   exc_out, exccode_out             held entry carries an AdEL fetch exception / its code
//   ok_to_branch                     delay-slot entry is held (mirrors valid_out)
//   pc_update, pc_new                decode redirect, only meaningful on an accepting cycle
//   exc_flush, exc_target            exception/ERET flush from commit, overrides everything

module stage_if #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [4:0]  EXC_ADEL = 5'h04
) (
    input  logic        clk,
    input  logic        resetn,

    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,

    output logic        valid_out,
    input  logic        stall_in,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        exc_out,
    output logic [4:0]  exccode_out,
    output logic        ok_to_branch,

    input  logic        pc_update,
    input  logic [31:0] pc_new,

    input  logic        exc_flush,
    input  logic [31:0] exc_target
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] fpc;
    logic [31:0] fpc_nxt;
    // Set when the response currently in flight belongs to a flushed PC and
    // must be thrown away when it arrives.
    logic        drop;
    logic        drop_nxt;

    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc;

    logic        load_en;
    logic [31:0] load_pc;
    logic [31:0] load_instr;
    logic        load_exc;

    logic        misaligned;
    logic        accept;

    assign misaligned = (fpc[1:0] != 2'b00);
    // A misaligned PC never reaches the bus; it turns straight into an AdEL entry.
    assign inst_req   = (state == S_REQ) && !misaligned;
    assign inst_addr  = fpc;
    assign valid_out  = (state == S_HOLD);
    assign accept     = valid_out && !stall_in;

    assign pc_out       = out_pc;
    assign instr_out    = out_instr;
    assign exc_out      = out_exc;
    assign exccode_out  = out_exc ? EXC_ADEL : 5'd0;
    assign ok_to_branch = valid_out;

    always_comb begin
        state_nxt  = state;
        fpc_nxt    = fpc;
        drop_nxt   = drop;
        load_en    = 1'b0;
        load_pc    = fpc;
        load_instr = 32'd0;
        load_exc   = 1'b0;

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end

            S_REQ: begin
                if (exc_flush) begin
                    // A request accepted on the flush cycle still returns data,
                    // which belongs to the old PC.
                    if (inst_req && inst_addr_ok) begin
                        drop_nxt  = 1'b1;
                        state_nxt = S_WAIT;
                    end
                end else if (misaligned) begin
                    load_en    = 1'b1;
                    load_pc    = fpc;
                    load_instr = 32'd0;
                    load_exc   = 1'b1;
                    state_nxt  = S_HOLD;
                end else if (inst_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (inst_data_ok) begin
                    if (drop || exc_flush) begin
                        // Stale (or just-flushed) response: discard and refetch
                        // from the current fpc.
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        load_en    = 1'b1;
                        load_pc    = fpc;
                        load_instr = inst_rdata;
                        load_exc   = 1'b0;
                        state_nxt  = S_HOLD;
                    end
                end else if (exc_flush) begin
                    drop_nxt = 1'b1;
                end
            end

            S_HOLD: begin
                if (exc_flush) begin
                    state_nxt = S_REQ;
                end else if (accept) begin
                    fpc_nxt   = pc_update ? pc_new : (fpc + 32'd4);
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // The flush target wins over any redirect or sequential increment.
        if (exc_flush) begin
            fpc_nxt = exc_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            fpc   <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_nxt;
            fpc   <= fpc_nxt;
            drop  <= drop_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_pc    <= 32'd0;
            out_instr <= 32'd0;
            out_exc   <= 1'b0;
        end else if (load_en) begin
            out_pc    <= load_pc;
            out_instr <= load_instr;
            out_exc   <= load_exc;
        end
    end

    // Decode may only redirect on a cycle where it actually takes the entry.
    a_pc_update_on_accept: assert property (
        @(posedge clk) disable iff (!resetn)
        pc_update |-> (state == S_HOLD && !stall_in)
    );

    // Read data is only expected while a request is outstanding.
    a_data_ok_in_wait: assert property (
        @(posedge clk) disable iff (!resetn)
        inst_data_ok |-> (state == S_WAIT)
    );

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        valid_out;
    logic        stall_in;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        exc_out;
    logic [4:0]  exccode_out;
    logic        ok_to_branch;
    logic        pc_update;
    logic [31:0] pc_new;
    logic        exc_flush;
    logic [31:0] exc_target;

    stage_if #(.RESET_PC(32'hbfc00000), .EXC_ADEL(5'h04)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .valid_out    (valid_out),
        .stall_in     (stall_in),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .exc_out      (exc_out),
        .exccode_out  (exccode_out),
        .ok_to_branch (ok_to_branch),
        .pc_update    (pc_update),
        .pc_new       (pc_new),
        .exc_flush    (exc_flush),
        .exc_target   (exc_target)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // memory model controls
    logic        mem_en  = 1'b1;
    int          mem_lat = 1;
    logic        pend    = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hdead_beef;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] instr, input logic exc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.exc   = exc;
        return e;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: decides data_ok/addr_ok 1 time unit after each falling edge.
    initial begin
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (pend && pend_cnt == 0) begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_word(pend_addr);
                pend         = 1'b0;
            end else begin
                inst_data_ok = 1'b0;
                inst_rdata   = 32'd0;
                if (pend) pend_cnt = pend_cnt - 1;
            end
            if (inst_req && mem_en && !pend) begin
                inst_addr_ok = 1'b1;
                pend         = 1'b1;
                pend_cnt     = mem_lat - 1;
                pend_addr    = inst_addr;
            end else begin
                inst_addr_ok = 1'b0;
            end
        end
    end

    // Scoreboard: every entry decode takes is compared against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (resetn && valid_out && !stall_in) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got entry pc=%h, required no entry", pc_out);
                end else begin
                    e = sb.pop_front();
                    if (pc_out !== e.pc) begin
                        n_fail++;
                        $display("FAIL sb_pc: got %h required %h", pc_out, e.pc);
                    end
                    n_checks++;
                    if (instr_out !== e.instr) begin
                        n_fail++;
                        $display("FAIL sb_instr: got %h required %h", instr_out, e.instr);
                    end
                    n_checks++;
                    if (exc_out !== e.exc || exccode_out !== (e.exc ? 5'h04 : 5'h00)) begin
                        n_fail++;
                        $display("FAIL sb_exc: got %b/%h required %b", exc_out, exccode_out, e.exc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({inst_req, valid_out, exc_out, ok_to_branch} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctl: got req/vld/exc/otb=%b required 0000",
                     {inst_req, valid_out, exc_out, ok_to_branch});
        end
        n_checks++;
        if (pc_out !== 32'd0 || instr_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got pc=%h instr=%h required 0", pc_out, instr_out);
        end
        n_checks++;
        if (exccode_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_exccode: got %h required 00", exccode_out);
        end
    endtask

    task automatic test_fetch_seq();
        logic [31:0] addrs[$];
        int          vcyc[$];
        for (int k = 0; k < 3; k++)
            sb.push_back(mk_exp(RST_PC + 32'(4 * k), mem_word(RST_PC + 32'(4 * k)), 1'b0));
        resetn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (valid_out) vcyc.push_back(i);
            if (inst_req) addrs.push_back(inst_addr);
            if (i == 9) stall_in = 1'b1;
        end
        n_checks++;
        if (addrs.size() != 3) begin
            n_fail++;
            $display("FAIL seq_nreq: got %0d requests required 3", addrs.size());
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            a = (k < addrs.size()) ? addrs[k] : 32'hxxxxxxxx;
            n_checks++;
            if (a !== RST_PC + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_addr%0d: got %h required %h", k, a, RST_PC + 32'(4 * k));
            end
        end
        n_checks++;
        if (vcyc.size() != 3) begin
            n_fail++;
            $display("FAIL seq_nvalid: got %0d valid cycles required 3", vcyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (vcyc[k] != 3 * (k + 1)) begin
                    n_fail++;
                    $display("FAIL seq_vcycle%0d: got %0d required %0d", k, vcyc[k], 3 * (k + 1));
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid_out !== 1'b1 || inst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ctl: got vld=%b req=%b required 1/0", valid_out, inst_req);
            end
            n_checks++;
            if (pc_out !== 32'hbfc00008 || instr_out !== mem_word(32'hbfc00008)) begin
                n_fail++;
                $display("FAIL stall_hold: got pc=%h instr=%h required bfc00008/%h",
                         pc_out, instr_out, mem_word(32'hbfc00008));
            end
        end
        @(negedge clk);
        stall_in = 1'b0;
        sb.push_back(mk_exp(32'hbfc0000c, mem_word(32'hbfc0000c), 1'b0));
        sb.push_back(mk_exp(32'hbfc00010, mem_word(32'hbfc00010), 1'b0));
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_checks++;
                if (inst_req !== 1'b1 || inst_addr !== 32'hbfc0000c) begin
                    n_fail++;
                    $display("FAIL stall_next: got req=%b addr=%h required 1/bfc0000c", inst_req, inst_addr);
                end
            end
            if (i == 6) stall_in = 1'b1;
        end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'hbfc00010) begin
            n_fail++;
            $display("FAIL redir_hold: got vld=%b pc=%h required 1/bfc00010", valid_out, pc_out);
        end
        stall_in  = 1'b0;
        pc_update = 1'b1;
        pc_new    = 32'hbfc00100;
        sb.push_back(mk_exp(32'hbfc00100, mem_word(32'hbfc00100), 1'b0));
        @(negedge clk);
        pc_update = 1'b0;
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00100) begin
            n_fail++;
            $display("FAIL redir_addr: got req=%b addr=%h required 1/bfc00100", inst_req, inst_addr);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (inst_req === 1'b1 && inst_addr === 32'hbfc00014) begin
                n_fail++;
                $display("FAIL redir_nofetch: got fetch of %h required none", inst_addr);
            end
        end
    endtask

    task automatic test_flush_wait();
        mem_lat = 4;
        @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00104) begin
            n_fail++;
            $display("FAIL flush_pre: got req=%b addr=%h required 1/bfc00104", inst_req, inst_addr);
        end
        @(negedge clk);
        exc_flush  = 1'b1;
        exc_target = 32'hbfc00380;
        for (int i = 3; i <= 5; i++) begin
            @(negedge clk);
            exc_flush = 1'b0;
            mem_lat   = 1;
            n_checks++;
            if (valid_out !== 1'b0 || inst_req !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_wait%0d: got vld=%b req=%b required 0/0", i, valid_out, inst_req);
            end
        end
        @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00380 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_refetch: got req=%b addr=%h vld=%b required 1/bfc00380/0",
                     inst_req, inst_addr, valid_out);
        end
        sb.push_back(mk_exp(32'hbfc00380, mem_word(32'hbfc00380), 1'b0));
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_novalid: got %b required 0", valid_out);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        pc_update = 1'b1;
        pc_new    = 32'hbfc00102;
        @(negedge clk);
        pc_update = 1'b0;
        n_checks++;
        if (inst_req !== 1'b0 || inst_addr !== 32'hbfc00102) begin
            n_fail++;
            $display("FAIL mis_noreq: got req=%b addr=%h required 0/bfc00102", inst_req, inst_addr);
        end
        sb.push_back(mk_exp(32'hbfc00102, 32'd0, 1'b1));
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1 || ok_to_branch !== 1'b1 || exc_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mis_flags: got vld=%b otb=%b exc=%b required 1/1/1", valid_out, ok_to_branch, exc_out);
        end
        n_checks++;
        if (pc_out !== 32'hbfc00102 || instr_out !== 32'd0 || exccode_out !== 5'h04) begin
            n_fail++;
            $display("FAIL mis_data: got pc=%h instr=%h code=%h required bfc00102/0/04",
                     pc_out, instr_out, exccode_out);
        end
        pc_update = 1'b1;
        pc_new    = 32'hbfc00200;
        mem_lat   = 6;
        @(negedge clk);
        pc_update = 1'b0;
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00200) begin
            n_fail++;
            $display("FAIL mis_recover: got req=%b addr=%h required 1/bfc00200", inst_req, inst_addr);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_wait: got req=%b vld=%b required 0/0", inst_req, valid_out);
        end
        resetn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (inst_req !== 1'b0 || valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_in_reset%0d: got req=%b vld=%b required 0/0", i, inst_req, valid_out);
            end
        end
        mem_lat = 1;
        sb.push_back(mk_exp(RST_PC, mem_word(RST_PC), 1'b0));
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin
            n_fail++;
            $display("FAIL rmid_first: got req=%b addr=%h required 1/%h", inst_req, inst_addr, RST_PC);
        end
        repeat (2) @(negedge clk);
        mem_en = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00004 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_next: got req=%b addr=%h vld=%b required 1/bfc00004/0",
                     inst_req, inst_addr, valid_out);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        stall_in   = 1'b0;
        pc_update  = 1'b0;
        pc_new     = 32'd0;
        exc_flush  = 1'b0;
        exc_target = 32'd0;

        test_reset();
        test_fetch_seq();
        test_stall();
        test_redirect();
        test_flush_wait();
        test_misaligned();
        test_reset_mid();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries never delivered required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
